// File: rtl/ecc_pkg.sv
// Shared page geometry and page-buffer state encoding for the flash ECC path.
package ecc_pkg;

  localparam int PAGE_BYTES  = 528;
  localparam int DATA_BYTES  = 512;
  localparam int SPARE_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2,
    ST_READ    = 2'd3
  } pagebuf_state_t;

  // True when a playback index matches either injection address.
  function automatic logic err_hit(input logic [9:0] idx, input logic [9:0] a0,
                                   input logic [9:0] a1);
    return (idx == a0) || (idx == a1);
  endfunction

endpackage

// File: rtl/flash_page_ram.sv
// Page storage: one write port, one synchronous read port (1-cycle latency).
// Kept free of reset so it can be swapped for a compiled SRAM macro.
module flash_page_ram #(
  parameter int DEPTH = 528
) (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [9:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  input  logic [9:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rd_data;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Synchronous read port; output holds between reads.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/flash_page_buf.sv
// Flash page buffer: captures one encoded page, then plays it back on request.
// Optional FLASH_ERR_INJ_EN adds errEn/errAdrs0/errAdrs1 to zero selected playback bytes.
module flash_page_buf #(
  parameter int PAGE_BYTES = ecc_pkg::PAGE_BYTES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wrValid,
  input  logic [7:0] wrData,
  input  logic       clear,
  input  logic       rdStart,
`ifdef FLASH_ERR_INJ_EN
  input  logic       errEn,
  input  logic [9:0] errAdrs0,
  input  logic [9:0] errAdrs1,
`endif
  output logic [7:0] rdData,
  output logic       rdValid,
  output logic       pageFull,
  output logic       overflow,
  output logic [9:0] byteCount
);

  import ecc_pkg::*;

  localparam logic [9:0] LAST_IDX = 10'(PAGE_BYTES - 1);

  pagebuf_state_t r_state;
  logic [9:0]     r_byte_count;
  logic [9:0]     r_q_idx;
  logic           r_q_vld;
  logic [7:0]     r_rd_data;
  logic           r_rd_valid;
  logic           r_page_full;
  logic           r_overflow;

  logic           w_wr_en;
  logic           w_rd_en;
  logic [9:0]     w_rd_addr;
  logic [7:0]     w_ram_q;
  logic           w_err_hit;
  logic [7:0]     w_play_byte;

  // RAM port control; the read address runs one ahead of the output register.
  always_comb begin
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_rd_addr = 10'd0;
    if (clear) begin
      w_wr_en = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_CAPTURE: w_wr_en = wrValid;
        ST_FULL: begin
          w_rd_en   = rdStart;
          w_rd_addr = 10'd0;
        end
        ST_READ: begin
          w_rd_en   = r_q_vld && (r_q_idx != LAST_IDX);
          w_rd_addr = r_q_idx + 10'd1;
        end
        default: w_wr_en = 1'b0;
      endcase
    end
  end

  flash_page_ram #(.DEPTH(PAGE_BYTES)) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_byte_count),
    .wr_data (wrData),
    .rd_en   (w_rd_en),
    .rd_addr (w_rd_addr),
    .rd_data (w_ram_q)
  );

`ifdef FLASH_ERR_INJ_EN
  assign w_err_hit = errEn && err_hit(r_q_idx, errAdrs0, errAdrs1);
`else
  assign w_err_hit = 1'b0;
`endif
  assign w_play_byte = w_err_hit ? 8'h00 : w_ram_q;

  // Page buffer FSM with registered status and playback outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_byte_count <= 10'd0;
      r_q_idx      <= 10'd0;
      r_q_vld      <= 1'b0;
      r_rd_data    <= 8'h00;
      r_rd_valid   <= 1'b0;
      r_page_full  <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (clear) begin
      r_state      <= ST_IDLE;
      r_byte_count <= 10'd0;
      r_q_idx      <= 10'd0;
      r_q_vld      <= 1'b0;
      r_rd_data    <= 8'h00;
      r_rd_valid   <= 1'b0;
      r_page_full  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_CAPTURE: begin
          if (wrValid) begin
            r_byte_count <= r_byte_count + 10'd1;
            if (r_byte_count == LAST_IDX) begin
              r_state     <= ST_FULL;
              r_page_full <= 1'b1;
            end else begin
              r_state <= ST_CAPTURE;
            end
          end
        end
        ST_FULL: begin
          if (wrValid) begin
            r_overflow <= 1'b1;
          end
          if (rdStart) begin
            r_state <= ST_READ;
            r_q_vld <= 1'b1;
            r_q_idx <= 10'd0;
          end
        end
        ST_READ: begin
          if (wrValid) begin
            r_overflow <= 1'b1;
          end
          r_rd_valid <= r_q_vld;
          r_rd_data  <= r_q_vld ? w_play_byte : 8'h00;
          r_q_vld    <= w_rd_en;
          if (w_rd_en) begin
            r_q_idx <= w_rd_addr;
          end
          // Output register drained: page retained, ready for another playback.
          if (!r_q_vld) begin
            r_state <= ST_FULL;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rdData    = r_rd_data;
  assign rdValid   = r_rd_valid;
  assign pageFull  = r_page_full;
  assign overflow  = r_overflow;
  assign byteCount = r_byte_count;

endmodule

// File: tb/tb_flash_page_buf.sv
// Randomized bench for flash_page_buf against a page-array reference model.
module tb_flash_page_buf;

  localparam int PB = 528;

  logic       clk = 1'b0;
  logic       reset;
  logic       wrValid;
  logic [7:0] wrData;
  logic       clear;
  logic       rdStart;
  logic [7:0] rdData;
  logic       rdValid;
  logic       pageFull;
  logic       overflow;
  logic [9:0] byteCount;
`ifdef FLASH_ERR_INJ_EN
  logic       errEn;
  logic [9:0] errAdrs0;
  logic [9:0] errAdrs1;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] m_mem [PB];
  int         m_cnt;
  bit         m_full;
  bit         m_ovf;

  flash_page_buf #(.PAGE_BYTES(PB)) dut (
    .clk       (clk),
    .reset     (reset),
    .wrValid   (wrValid),
    .wrData    (wrData),
    .clear     (clear),
    .rdStart   (rdStart),
`ifdef FLASH_ERR_INJ_EN
    .errEn     (errEn),
    .errAdrs0  (errAdrs0),
    .errAdrs1  (errAdrs1),
`endif
    .rdData    (rdData),
    .rdValid   (rdValid),
    .pageFull  (pageFull),
    .overflow  (overflow),
    .byteCount (byteCount)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check_val({tag, "_cnt"},  32'(byteCount), 32'(m_cnt));
    check_val({tag, "_full"}, 32'(pageFull),  32'(m_full));
    check_val({tag, "_ovf"},  32'(overflow),  32'(m_ovf));
    check_val({tag, "_vld"},  32'(rdValid),   32'd0);
    check_val({tag, "_data"}, 32'(rdData),    32'd0);
  endtask

  task automatic do_clear;
    clear   = 1'b1;
    wrValid = 1'($urandom_range(1));
    wrData  = 8'($urandom);
    tick;
    clear   = 1'b0;
    wrValid = 1'b0;
    m_cnt  = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    check_status("clr");
  endtask

  // pat: 0 = i^(i>>8), 1 = all 0xFF, else random. gap: 0 none, 1 every 3rd cycle, 2 random.
  task automatic capture(input int pat, input int gap);
    int c = 0;
    logic [7:0] d;
    for (int i = 0; i < PB; i++) begin
      while ((gap == 1 && (c % 3) == 2) || (gap == 2 && $urandom_range(3) == 0)) begin
        wrValid = 1'b0;
        rdStart = (gap == 2) ? 1'($urandom_range(1)) : 1'b0;
        tick;
        rdStart = 1'b0;
        c++;
        if (gap == 2) check_val("cap_rdstart_ignored", 32'(rdValid), 32'd0);
      end
      case (pat)
        0:       d = 8'(i) ^ 8'(i >> 8);
        1:       d = 8'hFF;
        default: d = 8'($urandom);
      endcase
      wrValid = 1'b1;
      wrData  = d;
      tick;
      c++;
      m_mem[i] = d;
      m_cnt++;
      if (i == 99) begin
        check_val("cap_mid_cnt",  32'(byteCount), 32'd100);
        check_val("cap_mid_full", 32'(pageFull),  32'd0);
      end
    end
    wrValid = 1'b0;
    m_full  = 1'b1;
    check_status("cap");
  endtask

  // Plays the page; stop_at >= 0 returns right after byte stop_at is observed.
  task automatic play(input int stop_at);
    logic [7:0] exp;
    rdStart = 1'b1;
    tick;
    rdStart = 1'b0;
    check_val("play_first_edge_vld", 32'(rdValid), 32'd0);
    for (int k = 0; k < PB; k++) begin
      if (k < 500) begin
        rdStart = 1'($urandom_range(1));
        wrValid = ($urandom_range(7) == 0);
        wrData  = 8'($urandom);
        if (wrValid) m_ovf = 1'b1;
      end
      tick;
      rdStart = 1'b0;
      wrValid = 1'b0;
      exp = m_mem[k];
`ifdef FLASH_ERR_INJ_EN
      if (errEn && (k == int'(errAdrs0) || k == int'(errAdrs1))) exp = 8'h00;
`endif
      check_val("play_vld",  32'(rdValid), 32'd1);
      check_val("play_data", 32'(rdData),  32'(exp));
      if (k == stop_at) return;
    end
    tick;
    check_status("play_end");
  endtask

  initial begin
    reset   = 1'b0;
    wrValid = 1'b0;
    wrData  = 8'h00;
    clear   = 1'b0;
    rdStart = 1'b0;
`ifdef FLASH_ERR_INJ_EN
    errEn    = 1'b0;
    errAdrs0 = 10'd0;
    errAdrs1 = 10'd0;
`endif
    m_cnt  = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;

    #2;
    check_status("rst");
    repeat (2) tick;
    reset = 1'b1;
    tick;

    rdStart = 1'b1;
    tick;
    rdStart = 1'b0;
    check_val("idle_rdstart_ignored", 32'(rdValid), 32'd0);
    tick;
    check_val("idle_rdstart_ignored2", 32'(rdValid), 32'd0);

    // Continuous capture and playback, then a repeat playback.
    capture(0, 0);
    play(-1);
    play(-1);

    // Gapped capture must produce the same page and count.
    do_clear();
    capture(0, 1);
    play(-1);

    // 529th byte is discarded and flags overflow.
    wrValid = 1'b1;
    wrData  = 8'hA5;
    tick;
    wrValid = 1'b0;
    m_ovf = 1'b1;
    check_status("ovf");
    play(-1);
    check_val("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset in the middle of playback.
    play(200);
    reset = 1'b0;
    #1;
    m_cnt  = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    check_status("rst_rd");
    tick;
    check_status("rst_rd_held");
    reset   = 1'b1;
    rdStart = 1'b1;
    tick;
    rdStart = 1'b0;
    check_val("rst_idle_rdstart", 32'(rdValid), 32'd0);
    wrValid = 1'b1;
    wrData  = 8'h3C;
    tick;
    wrValid = 1'b0;
    check_val("rst_idle_first_write", 32'(byteCount), 32'd1);
    clear   = 1'b1;
    wrValid = 1'b1;
    tick;
    clear   = 1'b0;
    wrValid = 1'b0;
    check_val("clear_drops_write", 32'(byteCount), 32'd0);

    // Clear a full page, then capture and replay an all-0xFF page.
    capture(2, 2);
    do_clear();
    capture(1, 0);
    play(-1);

    // Random pages with random gaps.
    repeat (2) begin
      do_clear();
      capture(2, 2);
      play(-1);
    end

`ifdef FLASH_ERR_INJ_EN
    errEn    = 1'b1;
    errAdrs0 = 10'd12;
    errAdrs1 = 10'd171;
    play(-1);
    errAdrs0 = 10'($urandom_range(PB - 1));
    errAdrs1 = 10'd527;
    play(-1);
    errEn = 1'b0;
    play(-1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
